// File: rtl/rv2t_fetch_aligner_if.sv
// Fetch-word and instruction handshake bundle for the RV2T fetch aligner.
// The slave modport is the aligner itself; the master modport is its
// environment (instruction memory port upstream, decode downstream).
interface rv2t_fetch_aligner_if #(
  parameter int PC_WIDTH = 32
);
  logic                word_valid_i;
  logic                word_ready_o;
  logic [31:0]         word_i;
  logic                instr_valid_o;
  logic                instr_ready_i;
  logic [31:0]         instr_o;
  logic [PC_WIDTH-1:0] instr_pc_o;
  logic                instr_is_compressed_o;
  logic                instr_illegal_o;

  modport slave (
    input  word_valid_i, word_i, instr_ready_i,
    output word_ready_o, instr_valid_o, instr_o, instr_pc_o,
           instr_is_compressed_o, instr_illegal_o
  );

  modport master (
    output word_valid_i, word_i, instr_ready_i,
    input  word_ready_o, instr_valid_o, instr_o, instr_pc_o,
           instr_is_compressed_o, instr_illegal_o
  );
endinterface

// File: rtl/rv2t_fetch_aligner.sv
// RV2T fetch aligner: buffers 32-bit fetch words as 16-bit parcels, realigns
// 16/32-bit instructions across word boundaries and expands RV32C parcels
// into their RV32I equivalents.
module rv2t_fetch_aligner #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  DEPTH_HW = 8,
  parameter int                  C_EXT    = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush_i,
  input  logic [PC_WIDTH-1:0] flush_pc_i,
  rv2t_fetch_aligner_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH_HW);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic        illegal;
    logic [31:0] instr;
  } expand_t;

  // RV32C quadrants 0-2 to canonical RV32I; anything not listed is illegal.
  function automatic expand_t expand(input logic [15:0] c);
    expand_t    r;
    logic [4:0] rd, rs2, rdp, rs2p;
    logic [5:0] imm6;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[9:7]};
    rs2p = {2'b01, c[4:2]};
    imm6 = {c[12], c[6:2]};
    r.illegal = 1'b0;
    r.instr   = 32'h0;
    case ({c[15:13], c[1:0]})
      5'b000_00: begin // c.addi4spn
        r.instr   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rs2p, OP_IMM};
        r.illegal = (c[12:5] == 8'h00);
      end
      5'b010_00: // c.lw
        r.instr = {5'b0, c[5], c[12:10], c[6], 2'b00, rdp, 3'b010, rs2p, OP_LOAD};
      5'b110_00: // c.sw
        r.instr = {5'b0, c[5], c[12], rs2p, rdp, 3'b010, c[11:10], c[6], 2'b00, OP_STORE};
      5'b000_01: // c.addi / c.nop
        r.instr = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, OP_IMM};
      5'b001_01, 5'b101_01: // c.jal / c.j
        r.instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                   {8{c[12]}}, c[15] ? 5'd0 : 5'd1, OP_JAL};
      5'b010_01: begin // c.li
        r.instr   = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, OP_IMM};
        r.illegal = (rd == 5'd0);
      end
      5'b011_01: begin
        if (rd == 5'd2) begin // c.addi16sp
          r.instr   = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
          r.illegal = (imm6 == 6'd0);
        end else begin        // c.lui
          r.instr   = {{15{c[12]}}, c[6:2], rd, OP_LUI};
          r.illegal = (imm6 == 6'd0) || (rd == 5'd0);
        end
      end
      5'b100_01: begin
        case (c[11:10])
          2'b00: begin // c.srli
            r.instr   = {7'b0000000, c[6:2], rdp, 3'b101, rdp, OP_IMM};
            r.illegal = c[12] || (imm6 == 6'd0);
          end
          2'b01: begin // c.srai
            r.instr   = {7'b0100000, c[6:2], rdp, 3'b101, rdp, OP_IMM};
            r.illegal = c[12] || (imm6 == 6'd0);
          end
          2'b10: // c.andi
            r.instr = {{7{c[12]}}, c[6:2], rdp, 3'b111, rdp, OP_IMM};
          default: begin
            // c[12]=1 holds subw/addw and the reserved encodings.
            r.illegal = c[12];
            case (c[6:5])
              2'b00:   r.instr = {7'b0100000, rs2p, rdp, 3'b000, rdp, OP_REG};
              2'b01:   r.instr = {7'b0000000, rs2p, rdp, 3'b100, rdp, OP_REG};
              2'b10:   r.instr = {7'b0000000, rs2p, rdp, 3'b110, rdp, OP_REG};
              default: r.instr = {7'b0000000, rs2p, rdp, 3'b111, rdp, OP_REG};
            endcase
          end
        endcase
      end
      5'b110_01, 5'b111_01: // c.beqz / c.bnez
        r.instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rdp, {2'b00, c[13]},
                   c[11:10], c[4:3], c[12], OP_BRANCH};
      5'b000_10: begin // c.slli
        r.instr   = {7'b0000000, c[6:2], rd, 3'b001, rd, OP_IMM};
        r.illegal = c[12] || (imm6 == 6'd0);
      end
      5'b010_10: begin // c.lwsp
        r.instr   = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, OP_LOAD};
        r.illegal = (rd == 5'd0);
      end
      5'b100_10: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin // c.jr, rs1=0 reserved
            r.instr   = {12'h000, rd, 3'b000, 5'd0, OP_JALR};
            r.illegal = (rd == 5'd0);
          end else begin         // c.mv
            r.instr = {7'b0, rs2, 5'd0, 3'b000, rd, OP_REG};
          end
        end else if (rd == 5'd0 && rs2 == 5'd0) begin // c.ebreak
          r.instr = 32'h0010_0073;
        end else if (rs2 == 5'd0) begin               // c.jalr
          r.instr = {12'h000, rd, 3'b000, 5'd1, OP_JALR};
        end else begin                                // c.add
          r.instr = {7'b0, rs2, rd, 3'b000, rd, OP_REG};
        end
      end
      5'b110_10: // c.swsp
        r.instr = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, OP_STORE};
      default:   // FP, RV64/RV128 and reserved encodings
        r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  logic [15:0]         parcels [DEPTH_HW];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                drop_low;
  logic [PC_WIDTH-1:0] pc;

  logic [PTR_W-1:0]    rd_ptr_p1, wr_ptr_p1;
  logic [15:0]         h0, h1;
  logic                head_is_c;
  logic                push, pop;
  logic [CNT_W-1:0]    push_cnt, pop_cnt;
  expand_t             exp_c;

  assign rd_ptr_p1 = rd_ptr + 1'b1;
  assign wr_ptr_p1 = wr_ptr + 1'b1;
  assign h0        = parcels[rd_ptr];
  assign h1        = parcels[rd_ptr_p1];

  // Head decode, handshake qualification and output formatting.
  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    head_is_c                 = (C_EXT != 0) && (h0[1:0] != 2'b11);
    exp_c                     = expand(h0);
    bus.word_ready_o          = (count <= CNT_W'(DEPTH_HW - 2));
    bus.instr_valid_o         = 1'b0;
    bus.instr_o               = 32'h0;
    bus.instr_pc_o            = pc;
    bus.instr_is_compressed_o = 1'b0;
    bus.instr_illegal_o       = 1'b0;
    if (head_is_c) bus.instr_valid_o = (count >= CNT_W'(1)) && !flush_i;
    else           bus.instr_valid_o = (count >= CNT_W'(2)) && !flush_i;
    if (bus.instr_valid_o) begin
      if (head_is_c) begin
        bus.instr_is_compressed_o = 1'b1;
        bus.instr_illegal_o       = exp_c.illegal;
        bus.instr_o               = exp_c.illegal ? {16'h0, h0} : exp_c.instr;
      end else begin
        bus.instr_o         = {h1, h0};
        bus.instr_illegal_o = (h0[4:2] == 3'b111) || (h0[1:0] != 2'b11);
      end
    end
    push     = bus.word_valid_i && bus.word_ready_o && !flush_i;
    pop      = bus.instr_valid_o && bus.instr_ready_i;
    push_cnt = '0;
    pop_cnt  = '0;
    if (push) push_cnt = drop_low ? CNT_W'(1) : CNT_W'(2);
    if (pop)  pop_cnt  = head_is_c ? CNT_W'(1) : CNT_W'(2);
  end

  // Parcel storage write port; a half-dropped word stores only its upper parcel.
  // NOTE: the parcel array has no reset; count alone decides which entries
  // are meaningful, so clearing the storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      if (drop_low) begin
        parcels[wr_ptr] <= bus.word_i[31:16];
      end else begin
        parcels[wr_ptr]    <= bus.word_i[15:0];
        parcels[wr_ptr_p1] <= bus.word_i[31:16];
      end
    end
  end

  // Pointer, occupancy and PC state; flush overrides push and pop.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_low <= 1'b0;
      pc       <= RESET_PC;
    end else if (flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_low <= flush_pc_i[1];
      pc       <= flush_pc_i & ~PC_WIDTH'(1);
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(push_cnt);
        drop_low <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
        pc     <= pc + (head_is_c ? PC_WIDTH'(2) : PC_WIDTH'(4));
      end
      count <= count + push_cnt - pop_cnt;
    end
  end

endmodule
